usb_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single USB write FIFO port between up to four streaming sources: CPU/register path, INA, INB and USB loopback. It grants one source at a time for a bounded burst, forwards the granted words as registered `usb_wr_data`/`usb_wr_be`/`usb_wr_en` beats, and issues one `usb_wr_push` at the end of every burst. It sits between the source datapaths and the USB FIFO. It replaces the static `usb_wr_mux` selection; the per-source enables are driven from the register block.

---
 rtl/usb_wr_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_usb_wr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_wr_arbiter.sv
// usb_wr_arbiter: round-robin arbiter sharing the single USB write FIFO port
// between up to four streaming sources (CPU/regs, INA, INB, loopback).
// One source is granted at a time for a burst bounded by req_last, BURST_MAX
// or the source being disabled. Granted words leave as registered
// usb_wr_data/usb_wr_be/usb_wr_en beats. usb_wr_push marks the end of each
// non-empty burst.
//
// Optional feature: define USB_WR_ARB_TIMEOUT_EN to flush a burst that has
// seen TIMEOUT_CYCLES consecutive cycles without a transfer.
//
// Handshake: a word moves in a cycle exactly when req_valid[grant] and
// req_ready[grant] are both high. req_ready is combinational. It is high only
// for the granted source, only in GRANT, and only while usb_wr_fifo_full is
// low. A source may drop req_valid at any time without losing its grant.
//
// dbg_state exposes the FSM state (0=IDLE, 1=GRANT, 2=PUSH).
module usb_wr_arbiter #(
  parameter int NREQ           = 4,
  parameter int BURST_MAX      = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [4*NREQ-1:0]  req_be,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        usb_wr_data,
  output logic [3:0]         usb_wr_be,
  output logic               usb_wr_en,
  input  logic               usb_wr_fifo_full,
  output logic               usb_wr_push,
  output logic [1:0]         grant,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_PUSH  = 2'd2
  } state_e;

  localparam int            CW        = $clog2(BURST_MAX + 1);
  localparam logic [1:0]    GRANT_RST = 2'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST_MAX - 1);

  // Reject configurations outside the supported range at elaboration.
  if (NREQ < 2 || NREQ > 4 || BURST_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("usb_wr_arbiter: illegal parameter value");
  end

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    be_q, be_d;
  logic          en_q, en_d;
  logic          push_q, push_d;

  // Four-wide views so the granted index can address every vector safely.
  logic [3:0]    en_w, valid_w, last_w, cand_w, ready_w;
  logic [127:0]  data_w;
  logic [15:0]   be_w;
  logic [31:0]   data_a [4];
  logic [3:0]    be_a [4];

  logic          xfer;
  logic          burst_end;
  logic          idle_flush;
  logic          hit;
  logic [1:0]    pick;

  assign en_w    = 4'(req_en);
  assign valid_w = 4'(req_valid);
  assign last_w  = 4'(req_last);
  assign data_w  = 128'(req_data);
  assign be_w    = 16'(req_be);
  assign cand_w  = en_w & valid_w;

  // Split the flat word/byte-enable buses into per-source lanes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data_a[i] = data_w[32*i +: 32];
      be_a[i]   = be_w[4*i +: 4];
    end
  end

  assign xfer      = (state_q == ST_GRANT) && valid_w[grant_q] && !usb_wr_fifo_full;
  assign ready_w   = (state_q == ST_GRANT && !usb_wr_fifo_full) ? (4'b0001 << grant_q) : 4'b0000;
  assign req_ready = ready_w[NREQ-1:0];
  // The word moving this cycle closes the burst if marked last or if it fills the burst.
  assign burst_end = last_w[grant_q] || (cnt_q == CNT_LAST);

  // Round-robin search: first candidate starting after the last grant.
  always_comb begin : rr_search
    int idx;
    idx  = 0;
    hit  = 1'b0;
    pick = grant_q;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(grant_q) + k) % NREQ;
      if (cand_w[idx[1:0]]) begin
        hit  = 1'b1;
        pick = idx[1:0];
      end
    end
  end

`ifdef USB_WR_ARB_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_q, idle_d;

  // Count consecutive granted cycles without a transfer; cleared outside GRANT.
  always_comb begin
    idle_d = '0;
    if (state_q == ST_GRANT && !xfer) begin
      idle_d = idle_q + TW'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign idle_flush = (state_q == ST_GRANT) && !xfer && (idle_q == IDLE_LAST);
`else
  assign idle_flush = 1'b0;
`endif

  // State register with grant pointer and burst word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitration, burst termination and push sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_GRANT;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (burst_end) begin
            state_d = ST_PUSH;
          end
        end else if (!en_w[grant_q] || idle_flush) begin
          // An empty burst is released silently; a partial one is committed.
          state_d = (cnt_q != '0) ? ST_PUSH : ST_IDLE;
        end
      end
      ST_PUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next-values: capture the granted word on a transfer, push after PUSH.
  always_comb begin
    data_d = data_q;
    be_d   = be_q;
    en_d   = 1'b0;
    push_d = (state_q == ST_PUSH);
    if (xfer) begin
      data_d = data_a[grant_q];
      be_d   = be_a[grant_q];
      en_d   = 1'b1;
    end
  end

  // Registered FIFO-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      be_q   <= '0;
      en_q   <= 1'b0;
      push_q <= 1'b0;
    end else begin
      data_q <= data_d;
      be_q   <= be_d;
      en_q   <= en_d;
      push_q <= push_d;
    end
  end

  assign usb_wr_data = data_q;
  assign usb_wr_be   = be_q;
  assign usb_wr_en   = en_q;
  assign usb_wr_push = push_q;
  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_usb_wr_arbiter.sv
// Bench for usb_wr_arbiter (NREQ=4, BURST_MAX=4, TIMEOUT_CYCLES=16).
// Sources stream from per-source word tables. A burst-level reference model
// predicts every FIFO write and push with its cycle and grant.
module tb_usb_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int BMAX  = 4;
  localparam int TOUT  = 16;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_en, req_valid, req_last, req_ready;
  logic [127:0] req_data;
  logic [15:0]  req_be;
  logic [31:0]  usb_wr_data;
  logic [3:0]   usb_wr_be;
  logic         usb_wr_en, usb_wr_fifo_full, usb_wr_push, busy;
  logic [1:0]   grant, dbg_state;

  always #5 clk = ~clk;

  usb_wr_arbiter #(.NREQ(NREQ), .BURST_MAX(BMAX), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset),
    .req_en(req_en), .req_valid(req_valid), .req_data(req_data),
    .req_be(req_be), .req_last(req_last), .req_ready(req_ready),
    .usb_wr_data(usb_wr_data), .usb_wr_be(usb_wr_be), .usb_wr_en(usb_wr_en),
    .usb_wr_fifo_full(usb_wr_fifo_full), .usb_wr_push(usb_wr_push),
    .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- source tables and scoreboard ----------------
  logic [36:0] src_mem [4][DEPTH];   // {last, be, data}
  int          src_len [4];
  int          drv_head [4];
  int          mdl_head [4];
  logic [3:0]  en_mask;
  int          model_grant;
  int          cyc;
  int          total;
  int          bad;

  // event = {kind(1=push), cycle(32), grant(2), be(4), data(32)}
  logic [70:0] exp_q[$];
  logic [70:0] obs_q[$];

  function automatic logic [70:0] ev(input logic k, input int c, input logic [1:0] g,
                                     input logic [3:0] be, input logic [31:0] d);
    return {k, 32'(c), g, be, d};
  endfunction

  task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (drv_head[i] < src_len[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_be[4*i +: 4], req_data[32*i +: 32]} = src_mem[i][drv_head[i]];
      end else begin
        req_valid[i]        = 1'b0;
        req_last[i]         = 1'b0;
        req_be[4*i +: 4]    = 4'h0;
        req_data[32*i +: 32] = 32'h0;
      end
    end
    req_en = en_mask;
  endtask

  // One clock: sample at negedge, then update inputs just after posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (usb_wr_en)   obs_q.push_back(ev(1'b0, cyc, grant, usb_wr_be, usb_wr_data));
    if (usb_wr_push) obs_q.push_back(ev(1'b1, cyc, grant, 4'h0, 32'h0));
    check("ready_onehot", 71'($onehot0(req_ready)), 71'(1));
    if (usb_wr_fifo_full) check("ready_when_full", 71'(req_ready), 71'(0));
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) drv_head[i]++;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) begin
      src_len[i]  = 0;
      drv_head[i] = 0;
      mdl_head[i] = 0;
    end
  endtask

  task automatic put_word(input int s, input logic [31:0] d, input logic [3:0] be, input logic last);
    src_mem[s][src_len[s]] = {last, be, d};
    src_len[s]++;
  endtask

  // Burst-level model: candidates are enabled sources with words left, chosen
  // round-robin after the previous grant; a burst stops at last or BMAX words.
  task automatic model_run(input int a, output int t_end);
    int g, t, s, n;
    bit found;
    logic [36:0] w;
    g = model_grant;
    t = a;
    forever begin
      found = 1'b0;
      s = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && en_mask[(g + k) % 4] && mdl_head[(g + k) % 4] < src_len[(g + k) % 4]) begin
          found = 1'b1;
          s = (g + k) % 4;
        end
      end
      if (!found) break;
      n = 0;
      do begin
        w = src_mem[s][mdl_head[s]];
        mdl_head[s]++;
        exp_q.push_back(ev(1'b0, t + 2 + n, 2'(s), w[35:32], w[31:0]));
        n++;
      end while (!w[36] && n < BMAX && mdl_head[s] < src_len[s]);
      exp_q.push_back(ev(1'b1, t + n + 2, 2'(s), 4'h0, 32'h0));
      g = s;
      t = t + n + 2;
    end
    model_grant = g;
    t_end = t;
  endtask

  task automatic compare(input string tag, input bit with_time);
    logic [70:0] m, o;
    m = '1;
    if (!with_time) m[69:38] = '0;
    check({tag, "_count"}, 71'(obs_q.size()), 71'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : '1;
      check($sformatf("%s_ev%0d", tag, i), o & m, exp_q[i] & m);
    end
  endtask

  // Start streaming the loaded tables, predict, run to completion, compare.
  task automatic run_scenario(input string tag);
    int a, t_end;
    obs_q.delete();
    exp_q.delete();
    drive();
    a = cyc + 1;
    model_run(a, t_end);
    while (cyc < t_end + 3) tick();
    compare(tag, 1'b1);
    check({tag, "_busy_end"}, 71'(busy), 71'(0));
    check({tag, "_state_end"}, 71'(dbg_state), 71'(0));
  endtask

  task automatic gen_random();
    clear_sources();
    en_mask = 4'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++) begin
      int len;
      len = en_mask[i] ? int'($urandom_range(1, 10)) : int'($urandom_range(0, 3));
      for (int j = 0; j < len; j++) begin
        put_word(i, $urandom, 4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0) || (j == len - 1));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a, t_end, h0;
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    usb_wr_fifo_full = 1'b0;
    en_mask = 4'h0;
    req_valid = '0; req_last = '0; req_en = '0; req_data = '0; req_be = '0;
    clear_sources();
    drive();
    repeat (3) tick();

    // Reset values
    check("rst_wr_en", 71'(usb_wr_en), 71'(0));
    check("rst_push", 71'(usb_wr_push), 71'(0));
    check("rst_data", 71'(usb_wr_data), 71'(0));
    check("rst_be", 71'(usb_wr_be), 71'(0));
    check("rst_grant", 71'(grant), 71'(NREQ - 1));
    check("rst_busy", 71'(busy), 71'(0));
    check("rst_ready", 71'(req_ready), 71'(0));
    reset = 1'b0;
    model_grant = NREQ - 1;
    repeat (2) tick();

    // Source 0 alone, three words
    clear_sources();
    en_mask = 4'b0001;
    put_word(0, 32'hA0, 4'hF, 1'b0);
    put_word(0, 32'hA1, 4'hF, 1'b0);
    put_word(0, 32'hA2, 4'hF, 1'b1);
    run_scenario("single3");
    check("single3_grant", 71'(grant), 71'(0));

    // Sources 0 and 1 alternating, last every 2 words
    clear_sources();
    en_mask = 4'b0011;
    for (int j = 0; j < 6; j++) begin
      put_word(0, 32'h100 + 32'(j), 4'hF, j[0]);
      put_word(1, 32'h200 + 32'(j), 4'h3, j[0]);
    end
    run_scenario("alt01");

    // Source 2, ten words, bursts capped at BMAX
    clear_sources();
    en_mask = 4'b0100;
    for (int j = 0; j < 10; j++) put_word(2, 32'hC00 + 32'(j), 4'h5, j == 9);
    run_scenario("burstmax");

    // Randomized mixes, including disabled sources with data pending
    for (int r = 0; r < 6; r++) begin
      gen_random();
      run_scenario($sformatf("rand%0d", r));
    end

    // FIFO full for five cycles mid-burst
    clear_sources();
    en_mask = 4'b0001;
    for (int j = 0; j < 8; j++) put_word(0, 32'hF00 + 32'(j), 4'hE, j == 3 || j == 7);
    obs_q.delete();
    exp_q.delete();
    drive();
    a = cyc + 1;
    model_run(a, t_end);
    repeat (2) tick();
    usb_wr_fifo_full = 1'b1;
    h0 = drv_head[0];
    repeat (5) tick();
    check("full_no_xfer", 71'(drv_head[0]), 71'(h0));
    usb_wr_fifo_full = 1'b0;
    while (cyc < t_end + 8) tick();
    compare("full", 1'b0);

    // Reset during the second word of a 4-word burst
    clear_sources();
    en_mask = 4'b0001;
    for (int j = 0; j < 4; j++) put_word(0, 32'hD0 + 32'(j), 4'hF, j == 3);
    drive();
    for (int k = 0; k < 10 && drv_head[0] < 1; k++) tick();
    check("rst_mid_reached", 71'(drv_head[0]), 71'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_sources();
    drive();
    obs_q.delete();
    @(negedge clk);
    cyc++;
    check("rstmid_wr_en", 71'(usb_wr_en), 71'(0));
    check("rstmid_push", 71'(usb_wr_push), 71'(0));
    check("rstmid_data", 71'(usb_wr_data), 71'(0));
    check("rstmid_be", 71'(usb_wr_be), 71'(0));
    check("rstmid_grant", 71'(grant), 71'(NREQ - 1));
    check("rstmid_busy", 71'(busy), 71'(0));
    @(posedge clk);
    #1;
    repeat (6) tick();
    check("rstmid_no_push", 71'(obs_q.size()), 71'(0));
    model_grant = NREQ - 1;
    clear_sources();
    en_mask = 4'b0011;
    put_word(0, 32'hE0, 4'hF, 1'b1);
    put_word(1, 32'hE1, 4'hF, 1'b1);
    run_scenario("after_rst");

    // Source 1 sends two words then goes quiet
    clear_sources();
    en_mask = 4'b0010;
    put_word(1, 32'h11, 4'hF, 1'b0);
    put_word(1, 32'h12, 4'hF, 1'b0);
    obs_q.delete();
    exp_q.delete();
    drive();
    a = cyc + 1;
    exp_q.push_back(ev(1'b0, a + 2, 2'd1, 4'hF, 32'h11));
    exp_q.push_back(ev(1'b0, a + 3, 2'd1, 4'hF, 32'h12));
`ifdef USB_WR_ARB_TIMEOUT_EN
    exp_q.push_back(ev(1'b1, a + 3 + TOUT + 1, 2'd1, 4'h0, 32'h0));
    while (cyc < a + TOUT + 8) tick();
    compare("timeout", 1'b1);
    check("timeout_busy", 71'(busy), 71'(0));
`else
    while (cyc < a + 40) tick();
    compare("no_timeout", 1'b1);
    check("no_timeout_busy", 71'(busy), 71'(1));
    en_mask = 4'b0000;
    drive();
    exp_q.push_back(ev(1'b1, cyc + 3, 2'd1, 4'h0, 32'h0));
    a = cyc;
    while (cyc < a + 6) tick();
    compare("en_drop", 1'b1);
    check("en_drop_busy", 71'(busy), 71'(0));
`endif
    model_grant = 1;

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
